// File: rtl/si_packet_arbiter.sv
// Packet-granular round-robin merge of N AXI4-Stream time-tag streams.
// Optional SI_PACKET_ARB_STATS_EN adds per-input packet counters.
module si_packet_arbiter #(
  parameter  int N_INPUTS   = 4,
  parameter  int DATA_WIDTH = 128,
  localparam int ID_WIDTH   = $clog2(N_INPUTS),
  localparam int KEEP_W     = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_INPUTS-1:0]            s_tvalid,
  output logic [N_INPUTS-1:0]            s_tready,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [N_INPUTS*KEEP_W-1:0]     s_tkeep,
  input  logic [N_INPUTS-1:0]            s_tlast,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [DATA_WIDTH-1:0]          m_tdata,
  output logic [KEEP_W-1:0]              m_tkeep,
  output logic                           m_tlast,
`ifdef SI_PACKET_ARB_STATS_EN
  output logic [N_INPUTS*32-1:0]         pkt_count,
`endif
  output logic [ID_WIDTH-1:0]            m_tid
);

  generate
    if (N_INPUTS < 2 || N_INPUTS > 16 ||
        DATA_WIDTH % 32 != 0 || 256 % DATA_WIDTH != 0) begin : g_bad_cfg
      $error("si_packet_arbiter: bad parameters");
    end
  endgenerate

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] grant;
  logic [ID_WIDTH-1:0] next_ptr;

  logic                  slot_free;
  logic                  accept;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_W-1:0]     sel_keep;

  logic                  req_any;
  logic [ID_WIDTH-1:0]   req_idx;
  logic [ID_WIDTH:0]     scan;

  assign slot_free = !m_tvalid || m_tready;

  // Mux of the granted input
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (grant == ID_WIDTH'(i)) begin
        sel_valid = s_tvalid[i];
        sel_last  = s_tlast[i];
        sel_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = s_tkeep[i*KEEP_W +: KEEP_W];
      end
    end
  end

  always_comb begin
    s_tready = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      s_tready[i] = (state == BUSY) && slot_free &&
                    (grant == ID_WIDTH'(i));
    end
  end

  assign accept = (state == BUSY) && slot_free && sel_valid;

  // Scan from rr_ptr downward in priority; the nearest requester wins
  always_comb begin
    req_any = 1'b0;
    req_idx = rr_ptr;
    scan    = '0;
    for (int k = N_INPUTS - 1; k >= 0; k--) begin
      scan = {1'b0, rr_ptr} + (ID_WIDTH+1)'(k);
      if (scan >= (ID_WIDTH+1)'(N_INPUTS)) begin
        scan = scan - (ID_WIDTH+1)'(N_INPUTS);
      end
      if (s_tvalid[scan[ID_WIDTH-1:0]]) begin
        req_any = 1'b1;
        req_idx = scan[ID_WIDTH-1:0];
      end
    end
  end

  assign next_ptr = (grant == ID_WIDTH'(N_INPUTS - 1)) ?
                    '0 : grant + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      grant  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            grant <= req_idx;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (accept && sel_last) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
      m_tid    <= '0;
    end else if (accept) begin
      m_tvalid <= 1'b1;
      m_tdata  <= sel_data;
      m_tkeep  <= sel_keep;
      m_tlast  <= sel_last;
      m_tid    <= grant;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

`ifdef SI_PACKET_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= '0;
    end else if (accept && sel_last) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        if (grant == ID_WIDTH'(i)) begin
          pkt_count[i*32 +: 32] <= pkt_count[i*32 +: 32] + 32'd1;
        end
      end
    end
  end
`endif

endmodule
